ps2_keyboard_matrix: RTL
========================

Name: ps2_keyboard_matrix

Overview:
Converts a PS/2 keyboard (scan code set 2) into an emulated C64 8x8 keyboard matrix. It sits directly upstream of the c64 top-level keyboard connector: it consumes keyboard_ROW (CIA1 port A drive) and produces keyboard_COL (CIA1 port B sense). It also drives an active-low RESTORE line intended for the NMI input. Internally it is a filtered PS/2 serial receiver, a prefix-tracking decode FSM and a 64-bit key-state register.

Parameters:
FILTER_LEN, 8, consecutive equal dot_clk samples needed before the filtered ps2_clk level changes
TIMEOUT, 16000, dot_clk cycles with no falling ps2_clk edge inside a frame before the frame is aborted (about 2 ms at 7.88 MHz)

Ports:
dot_clk  in  1  system dot clock; the only clock
res_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
keyboard_ROW  in  8  matrix row drive from CIA1 PA; 0 = row selected
keyboard_COL  out  8  matrix column sense to CIA1 PB; 0 = pressed key on a selected row
restore_n  out  1  low while RESTORE is held
scan_valid  out  1  one-cycle strobe when a byte is received without error
scan_code  out  8  last good byte; updated together with scan_valid
frame_err  out  1  one-cycle strobe on parity, start, stop or timeout error

Behaviour:
- Reset (res_n low, asynchronous): key matrix cleared, restore_n=1, scan_valid=0, scan_code=00, frame_err=0, both FSMs idle, prefix flags cleared, filter state = 1. Result: keyboard_COL=FF for any keyboard_ROW.
- Input conditioning: ps2_clk and ps2_data pass through a 2-flop synchroniser. The filtered clock takes a new level only after FILTER_LEN identical consecutive samples. A falling edge of the filtered clock is a sample event.
- Receiver FSM states: IDLE, DATA, PARITY, STOP. Each transition happens on a sample event.
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE and assert no error.
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: parity is odd over data+parity. Latch the result -> STOP.
  - STOP: data=1 and parity OK -> scan_valid and scan_code update on the next cycle. Otherwise frame_err. Both cases -> IDLE.
- Timeout: in any state other than IDLE, a counter reloads on each sample event. When it reaches TIMEOUT -> frame_err, go to IDLE, partial byte discarded. The counter saturates and does not wrap.
- A byte with an error never affects the matrix or the prefix flags.
- Decode FSM, acting on each scan_valid in the same cycle:
  - F0 sets brk.
  - E0 sets ext.
  - E1, FA, AA, EE, FE, FF, 00: clear both flags, no key effect.
  - Any other byte: look up (ext, code). If mapped, set matrix[row][col] <= !brk. Clear both flags whether or not the byte was mapped.
  - Prefixes accumulate: E0 F0 xx is an extended release.
- RESTORE is mapped as (ext=1, 7D), i.e. PageUp. It drives restore_n = brk on the decode cycle and does not occupy a matrix position.
- Matrix output is combinational from registered state, with zero latency to keyboard_ROW changes: keyboard_COL[c] = NOT OR over r of (matrix[r][c] AND NOT keyboard_ROW[r]). Multiple selected rows AND their columns together; ghosting is not modelled.
- Latency: matrix bit updates 1 cycle after scan_valid, i.e. 2 cycles after the STOP sample event.
- Repeated make codes (typematic) rewrite the same value; no side effect.
- Mandatory mappings (row = PA bit, col = PB bit):
  - A 1C -> r1 c2
  - Return 5A -> r0 c1
  - Space 29 -> r7 c4
  - LShift 12 -> r1 c7
  - RShift 59 -> r6 c4
  - CrsrDown E0 72 -> r0 c7
  - CrsrRight E0 74 -> r0 c2
  - remaining C64 alphanumerics per the standard layout
- Non-extended 72 (keypad 2) is unmapped.

Decomposition:
- Shared package c64_kbd_pkg: the row/col/valid struct typedef, the PS/2 prefix constants (E0, F0, E1), the RESTORE code constant, and a function map_scancode(ext, code) returning the struct.
- Sub-module ps2_rx contains the synchroniser, glitch filter, receiver FSM and timeout logic, with outputs scan_valid, scan_code and frame_err.
- The top level holds the decode FSM, the matrix register and the column logic.

Test Plan:
- Reset: hold res_n=0 with keyboard_ROW=00 -> keyboard_COL=FF and restore_n=1. Release res_n -> outputs unchanged.
- Make/break of A: send 1C with keyboard_ROW=FD -> scan_valid with scan_code=1C, then keyboard_COL=FB. Set keyboard_ROW=FF -> FF. Send F0 1C with ROW=FD -> FF.
- Extended vs plain code: send E0 72 with ROW=FE -> COL=7F. Send E0 F0 72 -> FF. Send plain 72 -> FF, no change.
- Multi-key: A and Return held, ROW=FC -> COL=F9. ROW=FE -> FD. ROW=FD -> FB.
- Errors:
  - Frame 1C with bad parity -> frame_err pulse, no scan_valid, COL stays FF.
  - Start bit plus 3 data bits, then clock idle -> frame_err after TIMEOUT cycles. A following good 5A frame with ROW=FE -> COL=FD.
  - Pulses on ps2_clk shorter than FILTER_LEN -> no bit sampled.
- RESTORE: send E0 7D -> restore_n=0 and COL unaffected for ROW=00. Send E0 F0 7D -> restore_n=1.

Source files
------------

// File: rtl/c64_kbd_pkg.sv
// Shared types and constants for the PS/2 to C64 keyboard matrix bridge.
// Also holds the scan code set 2 to C64 matrix position lookup.
package c64_kbd_pkg;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [7:0] Ps2Ext      = 8'hE0;
    localparam logic [7:0] Ps2Break    = 8'hF0;
    localparam logic [7:0] Ps2Pause    = 8'hE1;
    localparam logic [7:0] RestoreCode = 8'h7D;

    function automatic key_pos_t kp(input logic [2:0] row, input logic [2:0] col);
        key_pos_t k;
        k.valid = 1'b1;
        k.row   = row;
        k.col   = col;
        return k;
    endfunction

    // Row is the CIA1 PA bit, col is the CIA1 PB bit of the C64 matrix.
    function automatic key_pos_t map_scancode(input logic ext, input logic [7:0] code);
        key_pos_t k;
        k = '0;
        if (ext) begin
            case (code)
                8'h72:   k = kp(3'd0, 3'd7);
                8'h74:   k = kp(3'd0, 3'd2);
                8'h6C:   k = kp(3'd6, 3'd3);
                default: k = '0;
            endcase
        end else begin
            case (code)
                8'h66:   k = kp(3'd0, 3'd0);
                8'h5A:   k = kp(3'd0, 3'd1);
                8'h83:   k = kp(3'd0, 3'd3);
                8'h05:   k = kp(3'd0, 3'd4);
                8'h04:   k = kp(3'd0, 3'd5);
                8'h03:   k = kp(3'd0, 3'd6);
                8'h26:   k = kp(3'd1, 3'd0);
                8'h1D:   k = kp(3'd1, 3'd1);
                8'h1C:   k = kp(3'd1, 3'd2);
                8'h25:   k = kp(3'd1, 3'd3);
                8'h1A:   k = kp(3'd1, 3'd4);
                8'h1B:   k = kp(3'd1, 3'd5);
                8'h24:   k = kp(3'd1, 3'd6);
                8'h12:   k = kp(3'd1, 3'd7);
                8'h2E:   k = kp(3'd2, 3'd0);
                8'h2D:   k = kp(3'd2, 3'd1);
                8'h23:   k = kp(3'd2, 3'd2);
                8'h36:   k = kp(3'd2, 3'd3);
                8'h21:   k = kp(3'd2, 3'd4);
                8'h2B:   k = kp(3'd2, 3'd5);
                8'h2C:   k = kp(3'd2, 3'd6);
                8'h22:   k = kp(3'd2, 3'd7);
                8'h3D:   k = kp(3'd3, 3'd0);
                8'h35:   k = kp(3'd3, 3'd1);
                8'h34:   k = kp(3'd3, 3'd2);
                8'h3E:   k = kp(3'd3, 3'd3);
                8'h32:   k = kp(3'd3, 3'd4);
                8'h33:   k = kp(3'd3, 3'd5);
                8'h3C:   k = kp(3'd3, 3'd6);
                8'h2A:   k = kp(3'd3, 3'd7);
                8'h46:   k = kp(3'd4, 3'd0);
                8'h43:   k = kp(3'd4, 3'd1);
                8'h3B:   k = kp(3'd4, 3'd2);
                8'h45:   k = kp(3'd4, 3'd3);
                8'h3A:   k = kp(3'd4, 3'd4);
                8'h42:   k = kp(3'd4, 3'd5);
                8'h44:   k = kp(3'd4, 3'd6);
                8'h31:   k = kp(3'd4, 3'd7);
                8'h4D:   k = kp(3'd5, 3'd1);
                8'h4B:   k = kp(3'd5, 3'd2);
                8'h4E:   k = kp(3'd5, 3'd3);
                8'h49:   k = kp(3'd5, 3'd4);
                8'h41:   k = kp(3'd5, 3'd7);
                8'h4C:   k = kp(3'd6, 3'd2);
                8'h59:   k = kp(3'd6, 3'd4);
                8'h55:   k = kp(3'd6, 3'd5);
                8'h4A:   k = kp(3'd6, 3'd7);
                8'h16:   k = kp(3'd7, 3'd0);
                8'h14:   k = kp(3'd7, 3'd2);
                8'h1E:   k = kp(3'd7, 3'd3);
                8'h29:   k = kp(3'd7, 3'd4);
                8'h11:   k = kp(3'd7, 3'd5);
                8'h15:   k = kp(3'd7, 3'd6);
                8'h76:   k = kp(3'd7, 3'd7);
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM
// and inter-bit timeout. Emits one-cycle strobes for good bytes and errors.
module ps2_rx
    import c64_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 16000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_err_o
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             filt_q, filt_d;
    logic [FiltW-1:0] fcnt_q, fcnt_d;
    rx_state_e        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             par_ok_q, par_ok_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       code_q, code_d;
    logic             sample, rx_bit, timeout;

    // Level only flips once the new value has been seen FILTER_LEN times in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign sample  = filt_q & ~filt_d;
    assign rx_bit  = data_sync_q[1];
    assign timeout = (state_q != StIdle) && (to_cnt_q == ToW'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (sample) begin
            case (state_q)
                StIdle:   if (!rx_bit) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_ok_d  = par_ok_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        to_cnt_d  = to_cnt_q;
        if (state_q == StIdle || sample) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != ToW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end else if (sample) begin
            case (state_q)
                StIdle:   bit_cnt_d = 3'd0;
                StData: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: par_ok_d = ^{shift_q, rx_bit};
                StStop: begin
                    if (rx_bit && par_ok_q) begin
                        valid_d = 1'b1;
                        code_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign scan_valid_o = valid_q;
    assign scan_code_o  = code_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to emulated C64 8x8 matrix: prefix decoder, key-state register
// and the combinational row-to-column sense path, plus the RESTORE line.
module ps2_keyboard_matrix
    import c64_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 16000
) (
    input  logic       dot_clk,
    input  logic       res_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] keyboard_ROW,
    output logic [7:0] keyboard_COL,
    output logic       restore_n,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic [63:0] matrix_q, matrix_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        restore_q, restore_d;
    logic        ignored;
    key_pos_t    key;

    ps2_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_ps2_rx (
        .clk_i       (dot_clk),
        .rst_ni      (res_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .scan_valid_o(scan_valid),
        .scan_code_o (scan_code),
        .frame_err_o (frame_err)
    );

    // Keyboard housekeeping replies and the pause prefix carry no key information.
    assign ignored = (scan_code == Ps2Pause) || (scan_code == 8'hFA) || (scan_code == 8'hAA) ||
                     (scan_code == 8'hEE) || (scan_code == 8'hFE) || (scan_code == 8'hFF) ||
                     (scan_code == 8'h00);
    assign key = map_scancode(ext_q, scan_code);

    always_comb begin
        matrix_d  = matrix_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        restore_d = restore_q;
        if (scan_valid) begin
            if (scan_code == Ps2Break) begin
                brk_d = 1'b1;
            end else if (scan_code == Ps2Ext) begin
                ext_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ignored) begin
                    if (ext_q && scan_code == RestoreCode) begin
                        restore_d = brk_q;
                    end else if (key.valid) begin
                        matrix_d[{key.row, key.col}] = ~brk_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge dot_clk or negedge res_n) begin
        if (!res_n) begin
            matrix_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            restore_q <= 1'b1;
        end else begin
            matrix_q  <= matrix_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            restore_q <= restore_d;
        end
    end

    always_comb begin
        keyboard_COL = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (matrix_q[r*8 + c] && !keyboard_ROW[r]) begin
                    keyboard_COL[c] = 1'b0;
                end
            end
        end
    end

    assign restore_n = restore_q;

endmodule
